// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between an upstream producer, the pipe_stage_reg skid stage
// and its downstream consumer. The stage uses the slave view.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_instr;
    logic [PC_W-1:0]   in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [PC_W-1:0]   out_pc;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry in-order skid buffer between IF and ID, with registered in_ready,
// flush support and saturating stall/bubble statistics counters.
module pipe_stage_reg #(
    parameter int unsigned          DATA_W = 32,
    parameter int unsigned          PC_W   = 32,
    parameter logic [DATA_W-1:0]    BUBBLE = '0,
    parameter int unsigned          CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic out_valid;
    logic in_xfer;
    logic out_xfer;

    always_comb begin
        out_valid = (state_q != EMPTY);
        in_xfer   = bus.in_valid & in_ready_q;
        out_xfer  = out_valid & bus.out_ready;
    end

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d      = HALF;
                    main_instr_d = bus.in_instr;
                    main_pc_d    = bus.in_pc;
                end
            end
            HALF: begin
                unique case ({in_xfer, out_xfer})
                    2'b11: begin
                        main_instr_d = bus.in_instr;
                        main_pc_d    = bus.in_pc;
                    end
                    2'b10: begin
                        state_d      = FULL;
                        skid_instr_d = bus.in_instr;
                        skid_pc_d    = bus.in_pc;
                    end
                    2'b01:   state_d = EMPTY;
                    default: state_d = HALF;
                endcase
            end
            FULL: begin
                if (out_xfer) begin
                    state_d      = HALF;
                    main_instr_d = skid_instr_q;
                    main_pc_d    = skid_pc_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush wins over every transfer; data registers keep their old
        // contents so out_pc still shows the last head entry while empty.
        if (bus.flush) begin
            state_d      = EMPTY;
            main_instr_d = main_instr_q;
            main_pc_d    = main_pc_q;
            skid_instr_d = skid_instr_q;
            skid_pc_d    = skid_pc_q;
        end

        in_ready_d = (state_d != FULL);
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid && !bus.out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!out_valid && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            main_instr_q <= '0;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            in_ready_q   <= 1'b1;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            in_ready_q   <= in_ready_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_instr = out_valid ? main_instr_q : BUBBLE;
    assign bus.out_pc    = main_pc_q;
    assign stall_cnt     = stall_cnt_q;
    assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_stage_reg;

    localparam int unsigned DW  = 32;
    localparam int unsigned PW  = 32;
    localparam logic [31:0] BUB = 32'h0000_0013;
    localparam int          CMAX = 65535;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    int          checks   = 0;
    int          failures = 0;

    pipe_stage_reg_if #(.DATA_W(DW), .PC_W(PW)) bus ();
    pipe_stage_reg_if #(.DATA_W(DW), .PC_W(PW)) sbus ();

    logic [15:0] stall_cnt, bubble_cnt;
    logic [2:0]  s_stall_cnt, s_bubble_cnt;

    pipe_stage_reg #(.DATA_W(DW), .PC_W(PW), .BUBBLE(BUB), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .PC_W(PW), .CNT_W(3)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .bus        (sbus),
        .stall_cnt  (s_stall_cnt),
        .bubble_cnt (s_bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO of held entries (capacity 2) plus counters.
    logic [31:0] mq_instr[$];
    logic [31:0] mq_pc[$];
    bit          model_ok = 0;
    bit          m_rdy    = 1;
    logic [31:0] m_last_pc = '0;
    int          m_stall  = 0;
    int          m_bubble = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int  pre;
        bit  in_x, out_x;
        pre = mq_instr.size();
        if (reset) begin
            mq_instr.delete();
            mq_pc.delete();
            m_rdy     = 1;
            m_last_pc = '0;
            m_stall   = 0;
            m_bubble  = 0;
            model_ok  = 1;
        end else begin
            if (pre > 0 && !bus.out_ready && m_stall < CMAX) m_stall++;
            if (pre == 0 && m_bubble < CMAX) m_bubble++;
            in_x  = bus.in_valid && m_rdy;
            out_x = (pre > 0) && bus.out_ready;
            if (bus.flush) begin
                mq_instr.delete();
                mq_pc.delete();
            end else begin
                if (out_x) begin
                    void'(mq_instr.pop_front());
                    void'(mq_pc.pop_front());
                end
                if (in_x) begin
                    mq_instr.push_back(bus.in_instr);
                    mq_pc.push_back(bus.in_pc);
                end
            end
            m_rdy = (mq_instr.size() < 2);
            if (mq_instr.size() > 0) m_last_pc = mq_pc[0];
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("out_valid", 64'(bus.out_valid), 64'(mq_instr.size() > 0));
            chk("in_ready",  64'(bus.in_ready),  64'(m_rdy));
            chk("out_instr", 64'(bus.out_instr), 64'((mq_instr.size() > 0) ? mq_instr[0] : BUB));
            chk("out_pc",    64'(bus.out_pc),    64'(m_last_pc));
            chk("stall_cnt", 64'(stall_cnt),     64'(m_stall));
            chk("bubble_cnt",64'(bubble_cnt),    64'(m_bubble));
        end
    end

    task automatic cyc(input logic rst, input logic fl, input logic iv,
                       input logic [31:0] ii, input logic [31:0] ip, input logic ordy);
        reset         = rst;
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_instr  = ii;
        bus.in_pc     = ip;
        bus.out_ready = ordy;
        @(negedge clk);
    endtask

    initial begin
        int pv, pr;
        sbus.in_valid  = 1'b0;
        sbus.in_instr  = '0;
        sbus.in_pc     = '0;
        sbus.flush     = 1'b0;
        sbus.out_ready = 1'b0;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_instr", 64'(bus.out_instr), 64'(BUB));
        chk("rst_out_pc",    64'(bus.out_pc),    64'd0);

        // Streaming
        cyc(0, 0, 1, 32'h11, 32'd4, 1);
        chk("strm_v1", 64'(bus.out_valid), 64'd1);
        chk("strm_i1", 64'(bus.out_instr), 64'h11);
        cyc(0, 0, 1, 32'h22, 32'd8, 1);
        chk("strm_i2", 64'(bus.out_instr), 64'h22);
        chk("strm_rdy", 64'(bus.in_ready), 64'd1);
        cyc(0, 0, 1, 32'h33, 32'd12, 1);
        chk("strm_i3", 64'(bus.out_instr), 64'h33);
        cyc(0, 0, 0, 0, 0, 1);
        chk("strm_end_v", 64'(bus.out_valid), 64'd0);
        chk("strm_end_i", 64'(bus.out_instr), 64'(BUB));
        chk("strm_end_pc", 64'(bus.out_pc), 64'd12);

        // Stall / skid
        cyc(0, 0, 1, 32'hA, 32'd4, 0);
        chk("skid_rdy1", 64'(bus.in_ready), 64'd1);
        cyc(0, 0, 1, 32'hB, 32'd8, 0);
        chk("skid_rdy2", 64'(bus.in_ready), 64'd0);
        chk("skid_headA", 64'(bus.out_instr), 64'hA);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("skid_stableA", 64'(bus.out_instr), 64'hA);
        chk("skid_stable_pc", 64'(bus.out_pc), 64'd4);
        cyc(0, 0, 0, 0, 0, 1);
        chk("skid_headB", 64'(bus.out_instr), 64'hB);
        chk("skid_pcB", 64'(bus.out_pc), 64'd8);
        chk("skid_rdy3", 64'(bus.in_ready), 64'd1);
        chk("skid_stalls", 64'(stall_cnt), 64'd3);
        cyc(0, 0, 0, 0, 0, 1);

        // Flush while FULL with a same-cycle input
        cyc(0, 0, 1, 32'hA, 32'd4, 0);
        cyc(0, 0, 1, 32'hB, 32'd8, 0);
        chk("fl_full", 64'(bus.in_ready), 64'd0);
        cyc(0, 1, 1, 32'hC, 32'd12, 0);
        chk("fl_v", 64'(bus.out_valid), 64'd0);
        chk("fl_i", 64'(bus.out_instr), 64'(BUB));
        chk("fl_rdy", 64'(bus.in_ready), 64'd1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("fl_noC", 64'(bus.out_valid), 64'd0);

        // Bubbles after reset, and saturation on the narrow-counter instance
        cyc(1, 0, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 0, 0);
        chk("bub_cnt5", 64'(bubble_cnt), 64'd5);
        chk("bub_pc", 64'(bus.out_pc), 64'd0);
        chk("bub_i", 64'(bus.out_instr), 64'(BUB));
        chk("sat_cnt5", 64'(s_bubble_cnt), 64'd5);
        repeat (2) cyc(0, 0, 0, 0, 0, 0);
        chk("sat_cnt7", 64'(s_bubble_cnt), 64'd7);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        chk("sat_hold", 64'(s_bubble_cnt), 64'd7);
        chk("sat_stall", 64'(s_stall_cnt), 64'd0);

        // Reset while FULL with flush asserted
        cyc(0, 0, 1, 32'hA, 32'd4, 0);
        cyc(0, 0, 1, 32'hB, 32'd8, 0);
        chk("rf_full", 64'(bus.in_ready), 64'd0);
        cyc(1, 1, 1, 32'hC, 32'd12, 1);
        chk("rf_v", 64'(bus.out_valid), 64'd0);
        chk("rf_rdy", 64'(bus.in_ready), 64'd1);
        chk("rf_i", 64'(bus.out_instr), 64'(BUB));
        chk("rf_pc", 64'(bus.out_pc), 64'd0);
        chk("rf_stall", 64'(stall_cnt), 64'd0);
        chk("rf_bub", 64'(bubble_cnt), 64'd0);

        // Randomized traffic with varying input/output pressure
        for (int blk = 0; blk < 6; blk++) begin
            pv = 30 + 12 * blk;
            pr = 90 - 14 * blk;
            repeat (500) begin
                cyc(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 99) < 4),
                    ($urandom_range(0, 99) < pv),
                    $urandom, $urandom,
                    ($urandom_range(0, 99) < pr));
            end
        end
        cyc(0, 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
